counter_cmd_sched: RTL and testbench

- Command scheduler that shares one WIDTH-bit event counter between NREQ host command sources (trigger-in endpoints) and an internal autocount prescaler.
- Latches single-cycle command pulses and arbitrates them: clear has absolute priority, inc/dec are round-robin, autocount is lowest priority.
- Applies the winning op and emits one-cycle status pulses for trigger-out endpoints.
- Sits between the okTriggerIn/okWireIn endpoint outputs and the okTriggerOut/okWireOut inputs, all in the sys_clk domain.

---
 rtl/counter_cmd_sched_pkg.sv | 18 +
 rtl/counter_cmd_sched_if.sv | 31 +++
 rtl/counter_cmd_sched_tick_prescaler.sv | 30 +++
 rtl/counter_cmd_sched.sv | 189 ++++++++++++++++++
 tb/tb_counter_cmd_sched.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/counter_cmd_sched_pkg.sv
// counters_pkg: shared definitions for the board event counters.
//   - op encoding used on the host command bus (2 bits per requester)
//   - default geometry for the counter, requester count and prescaler
package counters_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int          DEF_WIDTH      = 8;
  localparam int          DEF_NREQ       = 4;
  localparam int          DEF_DIV_W      = 24;
  localparam logic [23:0] DEF_DIV_RELOAD = 24'h100000;

endpackage

// File: rtl/counter_cmd_sched_if.sv
// counter_cmd_sched_if: host-side command/status bundle of the counter
// scheduler. master = endpoint side (trigger/wire endpoints), slave = scheduler.
//   req_valid/req_op      : per-requester command strobes, op in [2i+1:2i]
//   autocount_en/hold     : level controls
//   req_ack, count, *_pulse, drop_err, busy : status back to the host
interface counter_cmd_sched_if #(
  parameter int NREQ  = counters_pkg::DEF_NREQ,
  parameter int WIDTH = counters_pkg::DEF_WIDTH
);
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic              autocount_en;
  logic              hold;
  logic [NREQ-1:0]   req_ack;
  logic [WIDTH-1:0]  count;
  logic              eq_zero_pulse;
  logic              eq_max_pulse;
  logic              wrap_pulse;
  logic              drop_err;
  logic              busy;

  modport master (
    output req_valid, req_op, autocount_en, hold,
    input  req_ack, count, eq_zero_pulse, eq_max_pulse, wrap_pulse, drop_err, busy
  );

  modport slave (
    input  req_valid, req_op, autocount_en, hold,
    output req_ack, count, eq_zero_pulse, eq_max_pulse, wrap_pulse, drop_err, busy
  );
endinterface

// File: rtl/counter_cmd_sched_tick_prescaler.sv
// tick_prescaler: down-counting divider producing a one-cycle tick every
// DIV_RELOAD+1 enabled cycles. Held at DIV_RELOAD while disabled so the
// first tick after enabling always comes a full period later.
//   sys_clk : clock
//   reset   : synchronous, active high
//   en      : count enable (level)
//   tick    : combinational pulse in the cycle the counter sits at zero
import counters_pkg::*;

module tick_prescaler #(
  parameter int               DIV_W      = DEF_DIV_W,
  parameter logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DEF_DIV_RELOAD)
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge sys_clk) begin
    if (reset || !en) cnt_q <= DIV_RELOAD;
    else if (tick)    cnt_q <= DIV_RELOAD;
    else              cnt_q <= cnt_q - DIV_W'(1);
  end

endmodule

// File: rtl/counter_cmd_sched.sv
// counter_cmd_sched: shares one WIDTH-bit event counter between NREQ host
// command sources and an autocount prescaler.
//   sys_clk, reset : clock, synchronous active-high reset
//   bus (slave)    : req_valid/req_op strobes in, autocount_en/hold levels in;
//                    req_ack, count, eq_zero/eq_max/wrap pulses, drop_err, busy out
// Each requester owns a one-deep pending slot. Per cycle one op executes:
// pending clear (lowest index, ignores hold) > round-robin inc/dec > autocount.
// All status outputs are registered alongside count.
import counters_pkg::*;

module counter_cmd_sched #(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               NREQ       = DEF_NREQ,
  parameter int               DIV_W      = DEF_DIV_W,
  parameter logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DEF_DIV_RELOAD)
) (
  input logic                sys_clk,
  input logic                reset,
  counter_cmd_sched_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // pending slots
  logic [NREQ-1:0]       slot_vld;
  logic [NREQ-1:0][1:0]  slot_op;
  logic                  auto_pending;
  logic                  tick;

  // arbitration
  logic [PTR_W-1:0]      rr_ptr;
  logic                  clr_hit, rr_hit;
  logic [PTR_W-1:0]      clr_idx, rr_idx;
  logic [NREQ-1:0]       grant;
  logic                  auto_grant;
  logic                  exec;
  logic [1:0]            exec_op;
  logic                  rr_adv;
  logic [PTR_W-1:0]      rr_next;
  int                    j;

  // datapath
  logic [WIDTH-1:0]      count_q, next_count;
  logic                  wrap;
  logic [NREQ-1:0]       accept, drop;

  // registered status
  logic [NREQ-1:0]       ack_q;
  logic                  eq_zero_q, eq_max_q, wrap_q, drop_q;

  tick_prescaler #(
    .DIV_W      (DIV_W),
    .DIV_RELOAD (DIV_RELOAD)
  ) u_presc (
    .sys_clk (sys_clk),
    .reset   (reset),
    .en      (bus.autocount_en),
    .tick    (tick)
  );

  // Arbitration. Loops run downward so the lowest index / smallest
  // rr distance is the last (winning) assignment.
  always_comb begin
    clr_hit = 1'b0;
    clr_idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_op[i] == OP_CLR)) begin
        clr_hit = 1'b1;
        clr_idx = PTR_W'(i);
      end
    end

    // Clear slots also show up here, but this result is only used when
    // no clear is pending, so every hit is an inc/dec.
    rr_hit = 1'b0;
    rr_idx = '0;
    j      = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (slot_vld[j]) begin
        rr_hit = 1'b1;
        rr_idx = PTR_W'(j);
      end
    end

    grant      = '0;
    auto_grant = 1'b0;
    exec       = 1'b0;
    exec_op    = OP_NOP;
    rr_adv     = 1'b0;
    if (clr_hit) begin
      grant[clr_idx] = 1'b1;
      exec           = 1'b1;
      exec_op        = OP_CLR;
    end else if (!bus.hold && rr_hit) begin
      grant[rr_idx] = 1'b1;
      exec          = 1'b1;
      exec_op       = slot_op[rr_idx];
      rr_adv        = 1'b1;
    end else if (!bus.hold && auto_pending) begin
      auto_grant = 1'b1;
      exec       = 1'b1;
      exec_op    = OP_INC;
    end

    rr_next = (rr_idx == PTR_W'(NREQ-1)) ? '0 : rr_idx + PTR_W'(1);
  end

  // Counter arithmetic, modulo 2^WIDTH.
  always_comb begin
    next_count = count_q;
    wrap       = 1'b0;
    case (exec_op)
      OP_INC: begin
        next_count = count_q + WIDTH'(1);
        wrap       = &count_q;
      end
      OP_DEC: begin
        next_count = count_q - WIDTH'(1);
        wrap       = ~|count_q;
      end
      OP_CLR:  next_count = '0;
      default: ;
    endcase
  end

  // Capture: a slot serviced this cycle is free to take a new strobe.
  always_comb begin
    accept = '0;
    drop   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && (bus.req_op[2*i +: 2] != OP_NOP)) begin
        if (!slot_vld[i] || grant[i]) accept[i] = 1'b1;
        else                          drop[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      slot_vld <= '0;
      slot_op  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          slot_vld[i] <= 1'b1;
          slot_op[i]  <= bus.req_op[2*i +: 2];
        end else if (grant[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Ticks that land on an already-pending auto request merge into it.
  always_ff @(posedge sys_clk) begin
    if (reset || !bus.autocount_en) auto_pending <= 1'b0;
    else                            auto_pending <= (auto_pending && !auto_grant) || tick;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_q   <= '0;
      ack_q     <= '0;
      eq_zero_q <= 1'b0;
      eq_max_q  <= 1'b0;
      wrap_q    <= 1'b0;
      drop_q    <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      count_q   <= next_count;
      ack_q     <= grant;
      eq_zero_q <= exec && (next_count == '0);
      eq_max_q  <= exec && (&next_count);
      wrap_q    <= exec && wrap;
      if (|drop) drop_q <= 1'b1;
      if (rr_adv) rr_ptr <= rr_next;
    end
  end

  assign bus.count         = count_q;
  assign bus.req_ack       = ack_q;
  assign bus.eq_zero_pulse = eq_zero_q;
  assign bus.eq_max_pulse  = eq_max_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.drop_err      = drop_q;
  assign bus.busy          = (|slot_vld) || auto_pending;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Directed bench for counter_cmd_sched (NREQ=4, WIDTH=8, DIV_RELOAD=3).
// Each table row holds inputs for one cycle and the outputs expected just
// after the following clock edge; hand-written sequences cover reset.
import counters_pkg::*;

module tb_counter_cmd_sched;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  counter_cmd_sched_if #(.NREQ(4), .WIDTH(8)) bus();

  counter_cmd_sched #(
    .WIDTH(8), .NREQ(4), .DIV_W(24), .DIV_RELOAD(24'd3)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] vld;
    logic [7:0] op;
    logic       hold;
    logic       aen;
    logic [7:0] cnt;
    logic [3:0] ack;
    logic [4:0] flg;   // {eq_zero, eq_max, wrap, drop_err, busy}
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic row(input logic [3:0] vld, input logic [7:0] op, input logic hold,
                     input logic aen, input logic [7:0] cnt, input logic [3:0] ack,
                     input logic [4:0] flg);
    vec_t v;
    v.vld = vld; v.op = op; v.hold = hold; v.aen = aen;
    v.cnt = cnt; v.ack = ack; v.flg = flg;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [16:0] outs();
    return {bus.count, bus.req_ack, bus.eq_zero_pulse, bus.eq_max_pulse,
            bus.wrap_pulse, bus.drop_err, bus.busy};
  endfunction

  initial begin
    logic [3:0] ack_seen;
    int         first;

    reset = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.hold = 1'b0; bus.autocount_en = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_state", 32'(outs()), 32'(17'h0));

    //   vld     op            hold aen  cnt    ack     z m w d b
    // single inc
    row(4'b0001, 8'b00000001, 0, 0, 8'd0, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd1, 4'b0001, 5'b00000);
    row(4'b0000, 8'b00000000, 0, 0, 8'd1, 4'b0000, 5'b00000);
    // dec on 3 brings rr_ptr back to 0
    row(4'b1000, 8'b10000000, 0, 0, 8'd1, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd0, 4'b1000, 5'b10000);
    // contention: 0 inc, 1 dec, 2 inc
    row(4'b0111, 8'b00011001, 0, 0, 8'd0, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd1, 4'b0001, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd0, 4'b0010, 5'b10001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd1, 4'b0100, 5'b00000);
    // four incs, rr_ptr=3 -> order 3,0,1,2
    row(4'b1111, 8'b01010101, 0, 0, 8'd1, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd2, 4'b1000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd3, 4'b0001, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd4, 4'b0010, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd5, 4'b0100, 5'b00000);
    // clear under hold
    row(4'b0001, 8'b00000001, 1, 0, 8'd5, 4'b0000, 5'b00001);
    row(4'b1000, 8'b11000000, 1, 0, 8'd5, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 1, 0, 8'd0, 4'b1000, 5'b10001);
    row(4'b0000, 8'b00000000, 1, 0, 8'd0, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd1, 4'b0001, 5'b00000);
    // down to FF
    row(4'b0010, 8'b00001000, 0, 0, 8'd1, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'd0, 4'b0010, 5'b10000);
    row(4'b0100, 8'b00100000, 0, 0, 8'd0, 4'b0000, 5'b00001);
    row(4'b0000, 8'b00000000, 0, 0, 8'hFF, 4'b0100, 5'b01100);
    // inc on 1 under hold, second inc dropped, wrap to 00
    row(4'b0010, 8'b00000100, 1, 0, 8'hFF, 4'b0000, 5'b00001);
    row(4'b0010, 8'b00000100, 1, 0, 8'hFF, 4'b0000, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 0, 8'd0, 4'b0010, 5'b10110);
    row(4'b0000, 8'b00000000, 0, 0, 8'd0, 4'b0000, 5'b00010);
    // back-to-back strobe accepted into the freed slot
    row(4'b0001, 8'b00000001, 0, 0, 8'd0, 4'b0000, 5'b00011);
    row(4'b0001, 8'b00000001, 0, 0, 8'd1, 4'b0001, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 0, 8'd2, 4'b0001, 5'b00010);
    // nop strobe ignored, never acked
    row(4'b0001, 8'b00000000, 0, 0, 8'd2, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 0, 8'd2, 4'b0000, 5'b00010);
    // autocount, period 4
    row(4'b0000, 8'b00000000, 0, 1, 8'd2, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd2, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd2, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd2, 4'b0000, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 1, 8'd3, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd3, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd3, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd3, 4'b0000, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 1, 8'd4, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd4, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 1, 8'd4, 4'b0000, 5'b00010);
    // host inc strobed in the tick cycle wins, auto follows
    row(4'b0001, 8'b00000001, 0, 1, 8'd4, 4'b0000, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 1, 8'd5, 4'b0001, 5'b00011);
    row(4'b0000, 8'b00000000, 0, 1, 8'd6, 4'b0000, 5'b00010);
    row(4'b0000, 8'b00000000, 0, 0, 8'd6, 4'b0000, 5'b00010);

    foreach (tbl[i]) begin
      bus.req_valid    = tbl[i].vld;
      bus.req_op       = tbl[i].op;
      bus.hold         = tbl[i].hold;
      bus.autocount_en = tbl[i].aen;
      step();
      check($sformatf("row%0d", i), 32'(outs()),
            32'({tbl[i].cnt, tbl[i].ack, tbl[i].flg}));
    end

    // reset with all four slots pending and the prescaler mid-count
    bus.req_valid = 4'b1111; bus.req_op = 8'b01010101; bus.hold = 1'b1;
    step();
    bus.req_valid = '0; bus.req_op = '0;
    check("midflight_busy", 32'(outs()), 32'({8'd6, 4'b0000, 5'b00011}));
    bus.autocount_en = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.hold = 1'b0;
    check("reset_midflight", 32'(outs()), 32'(17'h0));

    // prescaler must restart from DIV_RELOAD: first auto inc on 5th edge
    ack_seen = '0;
    first    = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      ack_seen |= bus.req_ack;
      if (first == 0 && bus.count != 8'd0) first = k;
    end
    check("presc_restart", 32'(first), 32'd5);
    check("no_ack_after_reset", 32'(ack_seen), 32'd0);
    check("auto_count_12", 32'(bus.count), 32'd2);
    check("drop_cleared", 32'(bus.drop_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
